// File: rtl/rsa_rfid_pkg.sv
// Shared definitions for the RFID-side RSA engine: UART timing, control states
// and the hex-to-seven-segment decoder used by the result display.
package rsa_rfid_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT,
        REDUCE,
        EXP,
        FINISH,
        TX
    } state_t;

    // Active-low segments ordered {dp,g,f,e,d,c,b,a}; dp is always dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/rsa_modmult.sv
// 32-bit interleaved modular multiplier: result = a*b mod n in 1 load + 32 steps.
// Requires b < n so that two conditional subtractions keep the accumulator below n.
module rsa_modmult (
    input  logic        clk,
    input  logic        srst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] n,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    logic [31:0] a_reg, b_reg, n_reg;
    logic [34:0] acc_reg;
    logic [4:0]  cnt_reg;
    logic        busy_reg, done_reg;
    logic [34:0] n_ext, sum, sub1, sub2;

    always_comb begin
        n_ext = {3'b000, n_reg};
        sum   = (acc_reg << 1) + ({3'b000, b_reg} & {35{a_reg[31]}});
        sub1  = (sum  >= n_ext) ? sum  - n_ext : sum;
        sub2  = (sub1 >= n_ext) ? sub1 - n_ext : sub1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            n_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                a_reg    <= a;
                b_reg    <= b;
                n_reg    <= n;
                acc_reg  <= '0;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                acc_reg <= sub2;
                a_reg   <= a_reg << 1;
                cnt_reg <= cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = acc_reg[31:0];

endmodule

// File: rtl/rsa_rfid.sv
// RSA engine top: UART operand frame in, C = M^E mod N by constant-time
// right-to-left square-and-multiply, result on bus, seven-segment and UART reply.
module rsa_rfid
    import rsa_rfid_pkg::*;
#(
    parameter int BIT_CLKS = CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        go,
    output logic        tx,
    output logic [31:0] output_text,
    output logic        done,
    output logic [7:0]  sev_segment,
    output logic [7:0]  sev_segment1,
    output logic [7:0]  sev_segment2,
    output logic [7:0]  sev_segment3,
    output logic [7:0]  sev_segment4,
    output logic [7:0]  sev_segment5
);

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CLKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(BIT_CLKS / 2 - 1);

    state_t      state_reg, state_next;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg, rx_busy_reg;
    logic [15:0] rx_cnt_reg, tx_cnt_reg;
    logic [3:0]  rx_bit_reg, byte_cnt_reg;
    logic [7:0]  rx_shift_reg;
    logic        rx_en, rx_start, rx_tick, byte_valid;
    logic [95:0] frame_reg;
    logic [31:0] x_reg, r_reg, r_init, out_reg, n_val;
    logic        done_reg, sq_reg, tx_reg, tx_done;
    logic [4:0]  bit_idx_reg;
    logic [39:0] tx_shift_reg;
    logic [5:0]  tx_idx_reg;
    logic        mm_start, mm_busy, mm_done;
    logic [31:0] mm_a, mm_b, mm_result;

    assign n_val  = frame_reg[95:64];
    assign r_init = (n_val > 32'd1) ? 32'd1 : 32'd0;

    // Receiver only listens while a frame is being collected.
    assign rx_en      = (state_reg == IDLE) || (state_reg == RECV);
    assign rx_start   = rx_en && !rx_busy_reg && rx_prev_reg && !rx_sync_reg;
    assign rx_tick    = rx_busy_reg &&
                        (rx_cnt_reg == ((rx_bit_reg == 4'd0) ? HALF_LAST : BIT_LAST));
    assign byte_valid = rx_tick && (rx_bit_reg == 4'd9) && rx_sync_reg;
    assign tx_done    = (state_reg == TX) && (tx_cnt_reg == 16'd0) && (tx_idx_reg == 6'd40);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_busy_reg  <= 1'b0;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            if (!rx_en) begin
                rx_busy_reg <= 1'b0;
            end else if (rx_start) begin
                rx_busy_reg <= 1'b1;
                rx_cnt_reg  <= '0;
                rx_bit_reg  <= '0;
            end else if (rx_tick) begin
                rx_cnt_reg <= '0;
                if (rx_bit_reg == 4'd0) begin
                    if (rx_sync_reg) rx_busy_reg <= 1'b0;
                    else             rx_bit_reg  <= 4'd1;
                end else if (rx_bit_reg == 4'd9) begin
                    rx_busy_reg <= 1'b0;
                end else begin
                    rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_reg   <= rx_bit_reg + 4'd1;
                end
            end else if (rx_busy_reg) begin
                rx_cnt_reg <= rx_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next multiply is launched in the same cycle the previous one reports done,
    // so every modmult costs exactly 33 clocks back to back.
    always_comb begin
        state_next = state_reg;
        mm_start   = 1'b0;
        mm_a       = r_reg;
        mm_b       = x_reg;
        case (state_reg)
            IDLE:   if (byte_valid) state_next = RECV;
            RECV:   if (byte_valid && byte_cnt_reg == 4'd11) state_next = WAIT;
            WAIT:   if (go) state_next = REDUCE;
            REDUCE: begin
                if (!mm_busy && !mm_done) begin
                    mm_start = 1'b1;
                    mm_a     = frame_reg[63:32];
                    mm_b     = 32'd1;
                end else if (mm_done) begin
                    state_next = EXP;
                    mm_start   = 1'b1;
                    mm_a       = r_init;
                    mm_b       = mm_result;
                end
            end
            EXP: begin
                if (mm_done) begin
                    if (!sq_reg) begin
                        mm_start = 1'b1;
                        mm_a     = x_reg;
                        mm_b     = x_reg;
                    end else if (bit_idx_reg == 5'd31) begin
                        state_next = FINISH;
                    end else begin
                        mm_start = 1'b1;
                        mm_a     = r_reg;
                        mm_b     = mm_result;
                    end
                end
            end
            FINISH: state_next = TX;
            TX:     if (tx_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_reg    <= '0;
            byte_cnt_reg <= '0;
            x_reg        <= '0;
            r_reg        <= '0;
            sq_reg       <= 1'b0;
            bit_idx_reg  <= '0;
            out_reg      <= '0;
            done_reg     <= 1'b0;
            tx_reg       <= 1'b1;
            tx_shift_reg <= '1;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
        end else begin
            if (byte_valid) begin
                frame_reg    <= {rx_shift_reg, frame_reg[95:8]};
                byte_cnt_reg <= (byte_cnt_reg == 4'd11) ? 4'd0 : byte_cnt_reg + 4'd1;
            end
            if (rx_start) done_reg <= 1'b0;
            case (state_reg)
                REDUCE: if (mm_done) begin
                    x_reg       <= mm_result;
                    r_reg       <= r_init;
                    sq_reg      <= 1'b0;
                    bit_idx_reg <= '0;
                end
                EXP: if (mm_done) begin
                    if (!sq_reg) begin
                        if (frame_reg[bit_idx_reg]) r_reg <= mm_result;
                        sq_reg <= 1'b1;
                    end else begin
                        x_reg       <= mm_result;
                        sq_reg      <= 1'b0;
                        bit_idx_reg <= bit_idx_reg + 5'd1;
                    end
                end
                FINISH: begin
                    out_reg      <= r_reg;
                    done_reg     <= 1'b1;
                    tx_shift_reg <= {1'b1, r_reg[31:24], 1'b0, 1'b1, r_reg[23:16], 1'b0,
                                     1'b1, r_reg[15:8],  1'b0, 1'b1, r_reg[7:0],   1'b0};
                    tx_cnt_reg   <= '0;
                    tx_idx_reg   <= '0;
                end
                TX: begin
                    tx_cnt_reg <= (tx_cnt_reg == BIT_LAST) ? 16'd0 : tx_cnt_reg + 16'd1;
                    if (tx_cnt_reg == 16'd0 && tx_idx_reg != 6'd40) begin
                        tx_reg       <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b1, tx_shift_reg[39:1]};
                        tx_idx_reg   <= tx_idx_reg + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    rsa_modmult u_modmult (
        .clk    (clk),
        .srst   (reset),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .n      (n_val),
        .busy   (mm_busy),
        .done   (mm_done),
        .result (mm_result)
    );

    logic [7:0] seg_digits [6];
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_seg
            assign seg_digits[gi] = hex_to_seg(out_reg[4*gi +: 4]);
        end
    endgenerate

    assign sev_segment  = seg_digits[0];
    assign sev_segment1 = seg_digits[1];
    assign sev_segment2 = seg_digits[2];
    assign sev_segment3 = seg_digits[3];
    assign sev_segment4 = seg_digits[4];
    assign sev_segment5 = seg_digits[5];
    assign output_text  = out_reg;
    assign done         = done_reg;
    assign tx           = tx_reg;

endmodule

// File: tb/tb_rsa_rfid.sv
// Directed bench for rsa_rfid: UART frames in, result/segments/UART reply checked
// against hand-computed values, with a shortened bit time.
module tb_rsa_rfid;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset, rx, go, tx, done;
    logic [31:0] output_text;
    logic [7:0]  s0, s1, s2, s3, s4, s5;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    rsa_rfid #(.BIT_CLKS(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .go           (go),
        .tx           (tx),
        .output_text  (output_text),
        .done         (done),
        .sev_segment  (s0),
        .sev_segment1 (s1),
        .sev_segment2 (s2),
        .sev_segment3 (s3),
        .sev_segment4 (s4),
        .sev_segment5 (s5)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b1; wait_clks(CPB);
        rx = 1'b0; wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; wait_clks(CPB);
        end
        rx = stop; wait_clks(CPB);
        rx = 1'b1;
    endtask

    // Sends bytes first..last of {N,M,E}; a junk byte with a bad stop bit precedes byte bad_at.
    task automatic send_frame(input logic [31:0] e, m, n, input int first, last, bad_at);
        logic [95:0] f;
        f = {n, m, e};
        for (int k = first; k <= last; k++) begin
            if (k == bad_at) send_byte(8'hAA, 1'b0);
            send_byte(f[8*k +: 8], 1'b1);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int t;
        t = 0;
        b = '0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 50*CPB) begin
            @(negedge clk);
            t++;
        end
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic finish_frame(input string tag, input logic [31:0] exp, input int limit);
        int          cyc;
        logic [31:0] reply;
        logic [7:0]  b;
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_done"}, {31'b0, done}, 32'd1);
        check_val({tag, "_result"}, output_text, exp);
        for (int k = 0; k < 4; k++) begin
            recv_byte(b);
            reply[8*k +: 8] = b;
        end
        check_val({tag, "_tx"}, reply, exp);
        $display("frame %s: C=0x%08h after %0d clocks, tx reply 0x%08h", tag, output_text, cyc, reply);
        wait_clks(2*CPB);
    endtask

    function automatic logic [31:0] modpow(input logic [31:0] m, e, n);
        longint unsigned r, x;
        if (n <= 32'd1) return 32'd0;
        r = 1;
        x = 64'(m) % 64'(n);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % 64'(n);
            x = (x * x) % 64'(n);
        end
        return r[31:0];
    endfunction

    initial begin
        reset = 1'b1; rx = 1'b1; go = 1'b0;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(1);
        check_val("rst_tx", {31'b0, tx}, 32'd1);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_text", output_text, 32'd0);
        check_val("rst_seg0", {24'b0, s0}, 32'hC0);
        check_val("rst_seg1", {24'b0, s1}, 32'hC0);
        check_val("rst_seg2", {24'b0, s2}, 32'hC0);
        check_val("rst_seg3", {24'b0, s3}, 32'hC0);
        check_val("rst_seg4", {24'b0, s4}, 32'hC0);
        check_val("rst_seg5", {24'b0, s5}, 32'hC0);
        go = 1'b1;

        // E=65537, M=0x8DFD, N=5: 4^odd mod 5 = 4
        send_frame(32'h00010001, 32'h00008DFD, 32'd5, 0, 11, -1);
        finish_frame("small", 32'd4, 2200);
        check_val("small_seg0", {24'b0, s0}, 32'h99);
        check_val("small_seg1", {24'b0, s1}, 32'hC0);

        // First byte of the next frame drops done but keeps the old result
        send_frame(32'd10, 32'd2, 32'd1000, 0, 0, -1);
        check_val("hold_done", {31'b0, done}, 32'd0);
        check_val("hold_text", output_text, 32'd4);
        send_frame(32'd10, 32'd2, 32'd1000, 1, 11, -1);
        finish_frame("sqmul", 32'd24, 2200);
        check_val("sqmul_seg0", {24'b0, s0}, 32'h80);
        check_val("sqmul_seg1", {24'b0, s1}, 32'hF9);

        send_frame(32'd0, 32'd7, 32'd13, 0, 11, -1);
        finish_frame("e_zero", 32'd1, 2200);

        send_frame(32'd3, 32'd5, 32'd1, 0, 11, -1);
        finish_frame("n_one", 32'd0, 2200);

        send_frame(32'h00010001, 32'h7315365D, 32'h008A04ED, 0, 11, -1);
        finish_frame("big", modpow(32'h7315365D, 32'h00010001, 32'h008A04ED), 2200);

        // go low while the frame completes: stall, then exact latency once go rises
        go = 1'b0;
        send_frame(32'd3, 32'd5, 32'd23, 0, 11, -1);
        wait_clks(100);
        check_val("stall_done", {31'b0, done}, 32'd0);
        go = 1'b1;
        wait_clks(2147);
        check_val("lat_early", {31'b0, done}, 32'd0);
        wait_clks(1);
        check_val("lat_exact", {31'b0, done}, 32'd1);
        finish_frame("stall", 32'd10, 10);
        check_val("stall_seg0", {24'b0, s0}, 32'h88);

        // Framing error before byte 5: 11 good bytes must not complete the frame
        send_frame(32'd7, 32'd3, 32'd100, 0, 10, 5);
        wait_clks(2300);
        check_val("ferr_wait", {31'b0, done}, 32'd0);
        send_frame(32'd7, 32'd3, 32'd100, 11, 11, -1);
        finish_frame("ferr", 32'd87, 2200);
        check_val("ferr_seg0", {24'b0, s0}, 32'hF8);
        check_val("ferr_seg1", {24'b0, s1}, 32'h92);

        // Reset in the middle of exponentiation
        send_frame(32'hFFFFFFFF, 32'd12345, 32'd99991, 0, 11, -1);
        wait_clks(300);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        wait_clks(1);
        check_val("mid_rst_done", {31'b0, done}, 32'd0);
        check_val("mid_rst_tx", {31'b0, tx}, 32'd1);
        check_val("mid_rst_text", output_text, 32'd0);
        wait_clks(3000);
        check_val("mid_rst_idle", {31'b0, done}, 32'd0);
        send_frame(32'd13, 32'd2, 32'd10007, 0, 11, -1);
        finish_frame("after_rst", 32'h00002000, 2200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
